operand_entry_fsm: RTL and testbench

OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

---
 rtl/calc_pkg.sv | 69 ++++++
 rtl/operand_entry_fsm_if.sv | 23 ++
 rtl/bcd_alu.sv | 37 +++
 rtl/bcd_entry_reg.sv | 62 ++++++
 rtl/operand_entry_fsm.sv | 168 ++++++++++++++++
 tb/tb_operand_entry_fsm.sv | 212 +++++++++++++++++++++
 6 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: key codes, ALU operation codes,
// entry-FSM states and the BCD/binary conversion helpers used by the ALU.
package calc_pkg;

    localparam logic [3:0]  KEY_PLUS    = 4'hA;
    localparam logic [3:0]  KEY_MINUS   = 4'hB;
    localparam logic [3:0]  KEY_EQUALS  = 4'hC;
    localparam logic [3:0]  KEY_CLEAR   = 4'hD;

    localparam logic [1:0]  OP_ADD      = 2'b01;
    localparam logic [1:0]  OP_SUB      = 2'b10;

    localparam logic [13:0] BCD_MAX_BIN = 14'd9999;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        SHOW    = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        KIND_NONE   = 3'd0,
        KIND_DIGIT  = 3'd1,
        KIND_OPER   = 3'd2,
        KIND_EQUALS = 3'd3,
        KIND_CLEAR  = 3'd4
    } key_kind_e;

    // Unqualified strobes and the reserved codes E/F both collapse to KIND_NONE.
    function automatic key_kind_e classify_key(input logic valid, input logic [3:0] code);
        key_kind_e kind;
        kind = KIND_NONE;
        case (code)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8, 4'h9: kind = KIND_DIGIT;
            KEY_PLUS, KEY_MINUS:         kind = KIND_OPER;
            KEY_EQUALS:                  kind = KIND_EQUALS;
            KEY_CLEAR:                   kind = KIND_CLEAR;
            default:                     kind = KIND_NONE;
        endcase
        return valid ? kind : KIND_NONE;
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] code);
        return (code == KEY_MINUS) ? OP_SUB : OP_ADD;
    endfunction

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] v);
        logic [13:0] acc;
        acc = 14'd0;
        for (int i = 3; i >= 0; i--) begin
            acc = acc * 14'd10 + {10'd0, v[4*i +: 4]};
        end
        return acc;
    endfunction

    function automatic logic [15:0] bin_to_bcd(input logic [13:0] v);
        logic [13:0] rem;
        logic [15:0] out;
        rem = v;
        out = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            out[4*i +: 4] = 4'(rem % 14'd10);
            rem           = rem / 14'd10;
        end
        return out;
    endfunction

endpackage

// File: rtl/operand_entry_fsm_if.sv
// Keypad, ALU and display signals of the operand entry block, grouped as one bus.
interface operand_entry_fsm_if;

    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_result;
    logic [15:0] num1_bcd;
    logic [15:0] num2_bcd;
    logic [1:0]  operation;
    logic [15:0] disp_bcd;
    logic        result_valid;

    modport master (
        output key_valid, key_code, alu_result,
        input  num1_bcd, num2_bcd, operation, disp_bcd, result_valid
    );

    modport slave (
        input  key_valid, key_code, alu_result,
        output num1_bcd, num2_bcd, operation, disp_bcd, result_valid
    );

endinterface

// File: rtl/bcd_alu.sv
// Combinational 4-digit BCD ALU fed by the entry block: addition saturates at 9999,
// subtraction clamps at 0000.
module bcd_alu
    import calc_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    output logic [15:0] y
);

    logic [13:0] a_bin_s, b_bin_s, y_bin_s;
    logic [14:0] sum_s;

    assign a_bin_s = bcd_to_bin(a);
    assign b_bin_s = bcd_to_bin(b);
    assign sum_s   = {1'b0, a_bin_s} + {1'b0, b_bin_s};

    // Operation select with saturation at both ends of the 4-digit range.
    always_comb begin
        y_bin_s = a_bin_s;
        case (op)
            OP_ADD: begin
                if (sum_s > {1'b0, BCD_MAX_BIN}) y_bin_s = BCD_MAX_BIN;
                else                              y_bin_s = sum_s[13:0];
            end
            OP_SUB: begin
                if (a_bin_s >= b_bin_s) y_bin_s = a_bin_s - b_bin_s;
                else                    y_bin_s = 14'd0;
            end
            default: y_bin_s = a_bin_s;
        endcase
    end

    assign y = bin_to_bcd(y_bin_s);

endmodule

// File: rtl/bcd_entry_reg.sv
// One BCD operand: 16-bit nibble shift register with a digit counter.
// clr/load pick the base value for this edge; shift then appends a digit to it.
module bcd_entry_reg
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        shift,
    input  logic [3:0]  digit,
    output logic [15:0] value,
    output logic [2:0]  count
);

    localparam logic [2:0] CNT_MAX = 3'(MAX_DIGITS);

    logic [15:0] value_r, base_val_s, val_nxt_s;
    logic [2:0]  count_r, base_cnt_s, cnt_nxt_s;

    // Base selection then digit append; clr together with shift restarts at one digit.
    always_comb begin
        base_val_s = value_r;
        base_cnt_s = count_r;
        if (clr) begin
            base_val_s = 16'h0000;
            base_cnt_s = 3'd0;
        end else if (load) begin
            base_val_s = load_val;
            base_cnt_s = 3'd0;
        end else begin
            base_val_s = value_r;
            base_cnt_s = count_r;
        end

        if (shift && (base_cnt_s < CNT_MAX)) begin
            val_nxt_s = {base_val_s[11:0], digit};
            cnt_nxt_s = base_cnt_s + 3'd1;
        end else begin
            val_nxt_s = base_val_s;
            cnt_nxt_s = base_cnt_s;
        end
    end

    // Operand and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= 16'h0000;
            count_r <= 3'd0;
        end else begin
            value_r <= val_nxt_s;
            count_r <= cnt_nxt_s;
        end
    end

    assign value = value_r;
    assign count = count_r;

endmodule

// File: rtl/operand_entry_fsm.sv
// Keypad operand entry FSM: builds two BCD operands and the operation for the ALU,
// latches the ALU result on '=', supports operator chaining and clear.
module operand_entry_fsm
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    operand_entry_fsm_if.slave bus
);

    state_e      state_r, state_nxt_s;
    logic [1:0]  op_r, op_nxt_s;
    logic [15:0] res_r, res_nxt_s;
    logic        rv_r, rv_nxt_s;

    key_kind_e   kind_s;
    logic [1:0]  key_op_s;

    logic        a_clr_s, a_load_s, a_shift_s;
    logic [15:0] a_load_val_s, a_val_s;
    logic [2:0]  a_count_unused_s;
    logic        b_clr_s, b_shift_s;
    logic [15:0] b_val_s;
    logic [2:0]  b_cnt_s;
    logic [15:0] disp_s;

    assign kind_s   = classify_key(bus.key_valid, bus.key_code);
    assign key_op_s = key_to_op(bus.key_code);

    bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_entry_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (a_clr_s),
        .load     (a_load_s),
        .load_val (a_load_val_s),
        .shift    (a_shift_s),
        .digit    (bus.key_code),
        .value    (a_val_s),
        .count    (a_count_unused_s)
    );

    bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_entry_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr_s),
        .load     (1'b0),
        .load_val (16'h0000),
        .shift    (b_shift_s),
        .digit    (bus.key_code),
        .value    (b_val_s),
        .count    (b_cnt_s)
    );

    // Next-state and operand control decode; alu_result reflects the operands held this cycle.
    always_comb begin
        state_nxt_s  = state_r;
        op_nxt_s     = op_r;
        res_nxt_s    = res_r;
        rv_nxt_s     = 1'b0;
        a_clr_s      = 1'b0;
        a_load_s     = 1'b0;
        a_shift_s    = 1'b0;
        a_load_val_s = bus.alu_result;
        b_clr_s      = 1'b0;
        b_shift_s    = 1'b0;

        case (kind_s)
            KIND_CLEAR: begin
                state_nxt_s = ENTER_A;
                op_nxt_s    = OP_ADD;
                res_nxt_s   = 16'h0000;
                a_clr_s     = 1'b1;
                b_clr_s     = 1'b1;
            end
            KIND_DIGIT: begin
                case (state_r)
                    ENTER_A: a_shift_s = 1'b1;
                    ENTER_B: b_shift_s = 1'b1;
                    SHOW: begin
                        a_clr_s     = 1'b1;
                        a_shift_s   = 1'b1;
                        b_clr_s     = 1'b1;
                        state_nxt_s = ENTER_A;
                    end
                    default: state_nxt_s = ENTER_A;
                endcase
            end
            KIND_OPER: begin
                case (state_r)
                    ENTER_A: begin
                        op_nxt_s    = key_op_s;
                        b_clr_s     = 1'b1;
                        state_nxt_s = ENTER_B;
                    end
                    ENTER_B: begin
                        op_nxt_s = key_op_s;
                        // With B still empty the key only swaps the operator.
                        if (b_cnt_s != 3'd0) begin
                            a_load_s = 1'b1;
                            b_clr_s  = 1'b1;
                        end else begin
                            a_load_s = 1'b0;
                            b_clr_s  = 1'b0;
                        end
                    end
                    SHOW: begin
                        op_nxt_s     = key_op_s;
                        a_load_s     = 1'b1;
                        a_load_val_s = res_r;
                        b_clr_s      = 1'b1;
                        state_nxt_s  = ENTER_B;
                    end
                    default: state_nxt_s = ENTER_A;
                endcase
            end
            KIND_EQUALS: begin
                case (state_r)
                    ENTER_B: begin
                        res_nxt_s   = bus.alu_result;
                        rv_nxt_s    = 1'b1;
                        state_nxt_s = SHOW;
                    end
                    ENTER_A, SHOW: state_nxt_s = state_r;
                    default:       state_nxt_s = ENTER_A;
                endcase
            end
            default: state_nxt_s = state_r;
        endcase
    end

    // State, operation, result and result strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ENTER_A;
            op_r    <= OP_ADD;
            res_r   <= 16'h0000;
            rv_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            res_r   <= res_nxt_s;
            rv_r    <= rv_nxt_s;
        end
    end

    // Display follows whichever value the user is currently looking at.
    always_comb begin
        disp_s = 16'h0000;
        case (state_r)
            ENTER_A: disp_s = a_val_s;
            ENTER_B: begin
                if (b_cnt_s != 3'd0) disp_s = b_val_s;
                else                 disp_s = a_val_s;
            end
            SHOW:    disp_s = res_r;
            default: disp_s = 16'h0000;
        endcase
    end

    assign bus.num1_bcd     = a_val_s;
    assign bus.num2_bcd     = b_val_s;
    assign bus.operation    = op_r;
    assign bus.result_valid = rv_r;
    assign bus.disp_bcd     = disp_s;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Bench for operand_entry_fsm driving the real BCD ALU: directed key sequences and
// random key streams compared against a decimal-level calculator model.
module tb_operand_entry_fsm;
    import calc_pkg::*;

    localparam int MAX_DIGITS = 4;
    localparam int PH_A    = 0;
    localparam int PH_B    = 1;
    localparam int PH_SHOW = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Calculator model: operands as decimal integers with digit counts.
    int m_a, m_b, m_na, m_nb, m_res, m_phase;
    bit m_sub, m_rv;

    operand_entry_fsm_if bus ();

    operand_entry_fsm #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bcd_alu u_alu (
        .a  (bus.num1_bcd),
        .b  (bus.num2_bcd),
        .op (bus.operation),
        .y  (bus.alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int ref_alu(input int a, input int b, input bit sub);
        if (sub) return (a >= b) ? a - b : 0;
        return (a + b > 9999) ? 9999 : a + b;
    endfunction

    function automatic int ref_disp();
        if (m_phase == PH_SHOW) return m_res;
        if (m_phase == PH_B && m_nb > 0) return m_b;
        return m_a;
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_res = 0;
        m_phase = PH_A; m_sub = 1'b0; m_rv = 1'b0;
    endtask

    task automatic model_step(input logic valid, input logic [3:0] code);
        m_rv = 1'b0;
        if (!valid || code > 4'hD) return;
        if (code == 4'hD) begin
            model_reset();
            return;
        end
        if (code <= 4'h9) begin
            if (m_phase == PH_A) begin
                if (m_na < MAX_DIGITS) begin m_a = m_a * 10 + int'(code); m_na++; end
            end else if (m_phase == PH_B) begin
                if (m_nb < MAX_DIGITS) begin m_b = m_b * 10 + int'(code); m_nb++; end
            end else begin
                m_a = int'(code); m_na = 1; m_b = 0; m_nb = 0; m_phase = PH_A;
            end
        end else if (code == 4'hA || code == 4'hB) begin
            if (m_phase == PH_B && m_nb > 0) m_a = ref_alu(m_a, m_b, m_sub);
            else if (m_phase == PH_SHOW) begin m_a = m_res; m_na = 0; end
            m_b = 0; m_nb = 0; m_sub = (code == 4'hB); m_phase = PH_B;
        end else if (m_phase == PH_B) begin
            m_res = ref_alu(m_a, m_b, m_sub); m_rv = 1'b1; m_phase = PH_SHOW;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 16'h%h expected 16'h%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".num1"}, bus.num1_bcd, to_bcd(m_a));
        check({tag, ".num2"}, bus.num2_bcd, to_bcd(m_b));
        check({tag, ".op"},   {14'd0, bus.operation}, m_sub ? 16'd2 : 16'd1);
        check({tag, ".disp"}, bus.disp_bcd, to_bcd(ref_disp()));
        check({tag, ".rv"},   {15'd0, bus.result_valid}, {15'd0, m_rv});
    endtask

    task automatic press(input logic valid, input logic [3:0] code, input string tag);
        @(negedge clk);
        bus.key_valid = valid;
        bus.key_code  = code;
        @(posedge clk);
        model_step(valid, code);
        #1;
        bus.key_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic keys(input string seq, input string tag);
        logic [3:0] c;
        for (int i = 0; i < seq.len(); i++) begin
            case (seq[i])
                "+":     c = 4'hA;
                "-":     c = 4'hB;
                "=":     c = 4'hC;
                "C":     c = 4'hD;
                default: c = 4'(seq[i] - 8'h30);
            endcase
            press(1'b1, c, tag);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        repeat (3) @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       v;
        logic [3:0] c;
        int         r;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("por");
        check("por.disp_const", bus.disp_bcd, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        keys("12+34=", "add");
        check("add.disp_const", bus.disp_bcd, 16'h0046);
        check("add.rv_pulse", {15'd0, bus.result_valid}, 16'd1);
        press(1'b0, 4'h0, "add_idle");
        check("add.rv_drop", {15'd0, bus.result_valid}, 16'd0);

        keys("C12345", "maxdig");
        check("maxdig.num1_const", bus.num1_bcd, 16'h1234);

        keys("C9999+1=", "sat");
        check("sat.disp_const", bus.disp_bcd, 16'h9999);
        keys("-99999=", "floor");
        check("floor.disp_const", bus.disp_bcd, 16'h0000);

        keys("C2+3+", "chain");
        check("chain.num1_const", bus.num1_bcd, 16'h0005);
        keys("4=", "chain_eq");
        check("chain.disp_const", bus.disp_bcd, 16'h0009);

        keys("C7+-2=", "oprep");
        check("oprep.disp_const", bus.disp_bcd, 16'h0005);

        keys("C007", "lead0");
        check("lead0.num1_const", bus.num1_bcd, 16'h0007);
        keys("12", "lead0_cap");
        check("lead0.cap_const", bus.num1_bcd, 16'h0071);

        keys("C56+7", "pre_rst");
        apply_reset("midrst");
        check("midrst.num2_const", bus.num2_bcd, 16'h0000);
        keys("56+7", "pre_clr");
        keys("C", "clr");
        check("clr.num1_const", bus.num1_bcd, 16'h0000);

        keys("3+4", "idle_pre");
        press(1'b0, 4'h3, "idle_v0");
        press(1'b1, 4'hE, "idle_e");
        press(1'b1, 4'hF, "idle_f");
        check("idle.num2_const", bus.num2_bcd, 16'h0004);
        keys("=", "rv_rst_pre");
        apply_reset("rv_rst");

        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 7) != 0);
            r = int'($urandom_range(0, 19));
            c = 4'((r < 16) ? r : 10 + (r - 16) % 3);
            press(v, c, "rnd");
            if (i % 200 == 199) apply_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
